// File: rtl/spatial_footprint_prefetcher.sv
// PC+offset spatial-footprint prefetcher: AT accumulates region footprints,
// a direct-mapped PHT learns them on eviction, and an engine replays them.
// Ports:
//   clk, rst (async, active-low)
//   up_address_i, up_pc_i, up_miss_i, up_valid_i, up_prefetched_i : access
//   pf_enable_i : issue enable
//   lo_ready_i, lo_prefetch_address_o, lo_prefetch_valid_o : prefetch port
//   busy_o : blocks pending, drop_count_o : saturating dropped PHT hits
module spatial_footprint_prefetcher #(
  parameter int ADDR_WIDTH        = 64,
  parameter int PC_WIDTH          = 64,
  parameter int BLOCK_OFFSET_BITS = 6,
  parameter int REGION_BLOCKS     = 32,
  parameter int AT_ENTRIES        = 16,
  parameter int PHT_ENTRIES       = 64,
  parameter int PHT_TAG_WIDTH     = 10,
  parameter int MIN_FOOTPRINT     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] up_address_i,
  input  logic [PC_WIDTH-1:0]   up_pc_i,
  input  logic                  up_miss_i,
  input  logic                  up_valid_i,
  input  logic                  up_prefetched_i,
  input  logic                  pf_enable_i,
  input  logic                  lo_ready_i,
  output logic [ADDR_WIDTH-1:0] lo_prefetch_address_o,
  output logic                  lo_prefetch_valid_o,
  output logic                  busy_o,
  output logic [15:0]           drop_count_o
);

  localparam int OFF_W = $clog2(REGION_BLOCKS);
  localparam int REG_W = ADDR_WIDTH - BLOCK_OFFSET_BITS - OFF_W;
  localparam int IDX_W = $clog2(PHT_ENTRIES);
  localparam int TAG_W = PHT_TAG_WIDTH;
  localparam int AT_IW = (AT_ENTRIES > 1) ? $clog2(AT_ENTRIES) : 1;
  localparam int CNT_W = $clog2(REGION_BLOCKS + 1);
  localparam logic [AT_IW-1:0] AGE_MAX = AT_IW'(AT_ENTRIES - 1);
  localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_FOOTPRINT);

  typedef logic [REGION_BLOCKS-1:0] fp_t;

  // access decode
  logic [REG_W-1:0] region;
  logic [OFF_W-1:0] off;
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  fp_t              off_mask;
  logic             qual;

  assign region = up_address_i[ADDR_WIDTH-1 -: REG_W];
  assign off    = up_address_i[BLOCK_OFFSET_BITS +: OFF_W];
  assign idx    = up_pc_i[2 +: IDX_W] ^ IDX_W'(off);
  assign tag    = up_pc_i[2 + IDX_W +: TAG_W];
  assign off_mask = fp_t'(1) << off;
  assign qual   = up_valid_i & (up_miss_i | up_prefetched_i);

  logic unused_bits;
  assign unused_bits = ^{up_address_i[BLOCK_OFFSET_BITS-1:0],
                         up_pc_i[1:0],
                         up_pc_i[PC_WIDTH-1:2+IDX_W+TAG_W]};

  // tables
  logic [AT_ENTRIES-1:0] at_v;
  logic [REG_W-1:0]      at_region [AT_ENTRIES];
  logic [IDX_W-1:0]      at_idx    [AT_ENTRIES];
  logic [TAG_W-1:0]      at_tag    [AT_ENTRIES];
  fp_t                   at_fp     [AT_ENTRIES];
  logic [AT_IW-1:0]      at_age    [AT_ENTRIES];

  logic [PHT_ENTRIES-1:0] pht_v;
  logic [TAG_W-1:0]       pht_tag [PHT_ENTRIES];
  fp_t                    pht_fp  [PHT_ENTRIES];

  // issue engine
  logic [REG_W-1:0] base;
  fp_t              pending;
  fp_t              pend_nxt;
  logic [OFF_W-1:0] p;
  logic             valid;
  logic             fire;

  // AT search and victim selection
  logic             at_hit;
  logic [AT_IW-1:0] hit_id;
  logic             free_found;
  logic [AT_IW-1:0] free_id;
  logic [AT_IW-1:0] old_id;
  logic [AT_IW-1:0] old_age;
  logic [AT_IW-1:0] vic_id;
  logic [CNT_W-1:0] vic_pop;
  logic             vic_store;
  logic             pht_hit;
  logic             trigger;
  logic             pf_hit;

  always_comb begin
    at_hit     = 1'b0;
    hit_id     = '0;
    free_found = 1'b0;
    free_id    = '0;
    old_id     = '0;
    old_age    = at_age[0];
    for (int i = 0; i < AT_ENTRIES; i++) begin
      if (!at_hit && at_v[i] && at_region[i] == region) begin
        at_hit = 1'b1;
        hit_id = AT_IW'(i);
      end
      if (!free_found && !at_v[i]) begin
        free_found = 1'b1;
        free_id    = AT_IW'(i);
      end
    end
    // strict compare keeps the lowest index on equal ages
    for (int i = 1; i < AT_ENTRIES; i++) begin
      if (at_age[i] > old_age) begin
        old_age = at_age[i];
        old_id  = AT_IW'(i);
      end
    end
    vic_id = free_found ? free_id : old_id;
  end

  always_comb begin
    vic_pop = '0;
    for (int i = 0; i < REGION_BLOCKS; i++)
      vic_pop = vic_pop + CNT_W'(at_fp[vic_id][i]);
  end

  assign vic_store = at_v[vic_id] && (vic_pop >= MIN_CNT);
  // combinational read of the stored array yields pre-write contents
  assign pht_hit   = pht_v[idx] && (pht_tag[idx] == tag);
  assign trigger   = qual && !at_hit;
  assign pf_hit    = trigger && pht_hit && pf_enable_i;

  // lowest pending offset is the one presented
  always_comb begin
    p = '0;
    for (int i = REGION_BLOCKS - 1; i >= 0; i--)
      if (pending[i]) p = OFF_W'(i);
  end

  assign valid = |pending;
  assign fire  = valid && lo_ready_i;

  always_comb begin
    pend_nxt = pending;
    if (fire)
      pend_nxt[p] = 1'b0;
    if (qual && region == base && off != p)
      pend_nxt[off] = 1'b0;
    if (pf_hit && !valid)
      pend_nxt = pht_fp[idx] & ~off_mask;
    if (!pf_enable_i)
      pend_nxt = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      at_v         <= '0;
      pht_v        <= '0;
      pending      <= '0;
      base         <= '0;
      drop_count_o <= '0;
      for (int i = 0; i < AT_ENTRIES; i++)
        at_age[i] <= '0;
    end else begin
      if (qual) begin
        for (int i = 0; i < AT_ENTRIES; i++)
          if (at_v[i] && at_age[i] != AGE_MAX)
            at_age[i] <= at_age[i] + 1'b1;
        if (at_hit) begin
          at_age[hit_id] <= '0;
        end else begin
          at_v[vic_id]   <= 1'b1;
          at_age[vic_id] <= '0;
          if (vic_store)
            pht_v[at_idx[vic_id]] <= 1'b1;
        end
      end
      pending <= pend_nxt;
      if (pf_hit && !valid)
        base <= region;
      if (pf_hit && valid && drop_count_o != 16'hFFFF)
        drop_count_o <= drop_count_o + 16'd1;
    end
  end

  // payload fields are qualified by the valid bits, so no reset
  always_ff @(posedge clk) begin
    if (qual) begin
      if (at_hit) begin
        at_fp[hit_id] <= at_fp[hit_id] | off_mask;
      end else begin
        at_region[vic_id] <= region;
        at_idx[vic_id]    <= idx;
        at_tag[vic_id]    <= tag;
        at_fp[vic_id]     <= off_mask;
        if (vic_store) begin
          pht_tag[at_idx[vic_id]] <= at_tag[vic_id];
          pht_fp[at_idx[vic_id]]  <= at_fp[vic_id];
        end
      end
    end
  end

  assign lo_prefetch_valid_o   = valid;
  assign lo_prefetch_address_o = valid ?
    {base, p, {BLOCK_OFFSET_BITS{1'b0}}} : '0;
  assign busy_o = valid;

endmodule
